sdm_modulator: RTL

- Digital sigma-delta modulator: the transmit-side counterpart of the CIC decimators. Converts PCM samples into a 1-bit bitstream at clock rate.
- Accepts one sample every OSR clocks over a valid/ready handshake and holds it for OSR bitstream cycles (zero-order-hold interpolation).
- Runtime selects a 1st- or 2nd-order loop. Used as on-chip stimulus to loop back into the CIC filters and as a standalone 1-bit DAC source.

---
 rtl/sdm_pkg.sv | 21 ++
 rtl/sdm_input_buffer.sv | 54 +++++
 rtl/sdm_modulator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sdm_pkg.sv
// sdm_pkg: shared types and constants for the sigma-delta modulator.
// Holds the loop-order enum, dither LFSR constants and integrator saturation limit.
package sdm_pkg;

  typedef enum logic {
    SDM_ORDER1 = 1'b0,
    SDM_ORDER2 = 1'b1
  } sdm_order_e;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as zero-based bit indices
  localparam int          LFSR_TAP_A = 15;
  localparam int          LFSR_TAP_B = 13;
  localparam int          LFSR_TAP_C = 12;
  localparam int          LFSR_TAP_D = 10;

  function automatic int sat_limit(input int data_width);
    return (1 << (data_width + 2)) - 1;
  endfunction

endpackage

// File: rtl/sdm_input_buffer.sv
// sdm_input_buffer: one-entry valid/ready holding register for PCM samples.
// The modulator drains it with load_i at each load boundary.
module sdm_input_buffer #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  input  logic                  load_i,
  output logic                  sample_ready_o,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  r_full;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_transfer;
  logic                  w_full_next;

  assign w_transfer = sample_valid_i & r_ready;

  // A full buffer cannot accept, so drain and fill never coincide
  always_comb begin
    w_full_next = r_full;
    if (load_i & r_full) begin
      w_full_next = 1'b0;
    end else if (w_transfer) begin
      w_full_next = 1'b1;
    end else begin
      w_full_next = r_full;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_full  <= w_full_next;
      r_ready <= ~w_full_next;
      if (w_transfer) begin
        r_data <= sample_i;
      end
    end
  end

  assign sample_ready_o = r_ready;
  assign full_o         = r_full;
  assign data_o         = r_data;

endmodule

// File: rtl/sdm_modulator.sv
// sdm_modulator: PCM to 1-bit sigma-delta bitstream with runtime 1st/2nd order loop.
// Define SDM_DITHER_EN to add a 16-bit LFSR LSB dither ahead of the loop.
module sdm_modulator
  import sdm_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int OSR        = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  output logic                  sample_ready_o,
  input  logic                  order_i,
  output logic                  bitstream_o,
  output logic                  sample_strobe_o,
  output logic                  underflow_o
);

  localparam int N  = DATA_WIDTH;
  localparam int IW = DATA_WIDTH + 4;
  localparam int SW = DATA_WIDTH + 6;
  localparam int PW = $clog2(OSR);
  localparam logic signed [SW-1:0] LIM        = SW'(sat_limit(N));
  localparam logic signed [SW-1:0] HALF       = SW'(1 << (N - 1));
  localparam logic [PW-1:0]        PHASE_LAST = PW'(OSR - 1);

  function automatic logic signed [IW-1:0] clamp(input logic signed [SW-1:0] v);
    if (v > LIM) begin
      return IW'(LIM);
    end else if (v < -LIM) begin
      return IW'(-LIM);
    end else begin
      return IW'(v);
    end
  endfunction

  logic [PW-1:0]          r_phase;
  logic [N-1:0]           r_x;
  sdm_order_e             r_order;
  logic [N-1:0]           r_acc;
  logic signed [IW-1:0]   r_i1;
  logic signed [IW-1:0]   r_i2;
  logic                   r_bit;
  logic                   r_strobe;
  logic                   r_underflow;

  logic                   w_boundary;
  logic                   w_buf_full;
  logic [N-1:0]           w_buf_data;
  logic                   w_load;
  logic                   w_clear;
  logic [N-1:0]           w_x_eff;
  logic [N-1:0]           w_x_loop;
  logic [N:0]             w_s;
  logic signed [SW-1:0]   w_xc;
  logic signed [SW-1:0]   w_fb;
  logic signed [IW-1:0]   w_i1_next;
  logic signed [IW-1:0]   w_i2_next;

  sdm_input_buffer #(.DATA_WIDTH(N)) u_buf (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .load_i         (w_boundary),
    .sample_ready_o (sample_ready_o),
    .full_o         (w_buf_full),
    .data_o         (w_buf_data)
  );

  assign w_boundary = (r_phase == PHASE_LAST);
  assign w_load     = w_boundary & w_buf_full;
  assign w_clear    = w_boundary & (order_i != r_order);
  // The loaded sample drives the loop on the boundary edge itself
  assign w_x_eff    = w_load ? w_buf_data : r_x;

`ifdef SDM_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B] ^
                     r_lfsr[LFSR_TAP_C] ^ r_lfsr[LFSR_TAP_D];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_x_loop = (&w_x_eff) ? w_x_eff : (w_x_eff + {{(N-1){1'b0}}, r_lfsr[0]});
`else
  assign w_x_loop = w_x_eff;
`endif

  assign w_s       = {1'b0, r_acc} + {1'b0, w_x_loop};
  assign w_xc      = $signed({{(SW-N){1'b0}}, w_x_loop}) - HALF;
  assign w_fb      = r_bit ? HALF : -HALF;
  assign w_i1_next = clamp(SW'(r_i1) + w_xc - w_fb);
  assign w_i2_next = clamp(SW'(r_i2) + SW'(w_i1_next) - w_fb);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_phase     <= {PW{1'b0}};
      r_x         <= {1'b1, {(N-1){1'b0}}};
      r_order     <= SDM_ORDER1;
      r_acc       <= {N{1'b0}};
      r_i1        <= {IW{1'b0}};
      r_i2        <= {IW{1'b0}};
      r_bit       <= 1'b0;
      r_strobe    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_phase     <= w_boundary ? {PW{1'b0}} : (r_phase + PW'(1));
      r_x         <= w_x_eff;
      r_strobe    <= w_load;
      r_underflow <= w_boundary & ~w_buf_full;
      if (w_boundary) begin
        r_order <= sdm_order_e'(order_i);
      end
      if (w_clear) begin
        r_acc <= {N{1'b0}};
        r_i1  <= {IW{1'b0}};
        r_i2  <= {IW{1'b0}};
        r_bit <= 1'b0;
      end else if (r_order == SDM_ORDER1) begin
        r_acc <= w_s[N-1:0];
        r_bit <= w_s[N];
      end else begin
        r_i1  <= w_i1_next;
        r_i2  <= w_i2_next;
        r_bit <= ~w_i2_next[IW-1];
      end
    end
  end

  assign bitstream_o     = r_bit;
  assign sample_strobe_o = r_strobe;
  assign underflow_o     = r_underflow;

endmodule
